// File: rtl/ps2_kbd_rx_if.sv
// Receiver-to-core bundle for the PS/2 keyboard receiver.
// Carries received bytes, per-key pressed levels and frame error strobes.
interface ps2_kbd_rx_if;
  logic       rd_data_valid;
  logic [7:0] rd_data_payload;
  logic [5:0] keys_valid;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output rd_data_valid,
    output rd_data_payload,
    output keys_valid,
    output parity_error,
    output frame_error
  );

  modport slave (
    input rd_data_valid,
    input rd_data_payload,
    input keys_valid,
    input parity_error,
    input frame_error
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard host receiver: deframes 11-bit frames and tracks
// make/break/extended codes into pressed levels for six game keys.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6000
) (
  input  logic core_clk,
  input  logic core_rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_kbd_rx_if.master rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  logic [FW-1:0] flt_cnt;
  logic          clk_f;
  logic          fall;

  // clk_f flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      flt_cnt <= '0;
      clk_f   <= 1'b1;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != clk_f) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_f   <= clk_s2;
          flt_cnt <= '0;
          fall    <= clk_f;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_ok, par_ok_n;
  logic [TW-1:0] idle_cnt, idle_cnt_n;
  logic          brk_pend, brk_pend_n;
  logic          ext_pend, ext_pend_n;
  logic          valid_q, valid_n;
  logic [7:0]    pay_q, pay_n;
  logic [5:0]    keys_q, keys_n;
  logic          perr_q, perr_n;
  logic          ferr_q, ferr_n;
  logic          good;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      idle_cnt <= '0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      valid_q  <= 1'b0;
      pay_q    <= '0;
      keys_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_ok   <= par_ok_n;
      idle_cnt <= idle_cnt_n;
      brk_pend <= brk_pend_n;
      ext_pend <= ext_pend_n;
      valid_q  <= valid_n;
      pay_q    <= pay_n;
      keys_q   <= keys_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_ok_n   = par_ok;
    idle_cnt_n = idle_cnt;
    brk_pend_n = brk_pend;
    ext_pend_n = ext_pend;
    valid_n    = 1'b0;
    pay_n      = pay_q;
    keys_n     = keys_q;
    perr_n     = 1'b0;
    ferr_n     = 1'b0;
    good       = 1'b0;

    unique case (state)
      IDLE: begin
        idle_cnt_n = '0;
        if (fall && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_n = ^shreg ^ dat_s2;
          state_n  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (!dat_s2)     ferr_n = 1'b1;
          else if (par_ok) good   = 1'b1;
          else             perr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // a real edge always wins over a timeout landing on the same cycle
    if (state != IDLE) begin
      if (fall) begin
        idle_cnt_n = '0;
      end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n    = IDLE;
        ferr_n     = 1'b1;
        idle_cnt_n = '0;
      end else begin
        idle_cnt_n = idle_cnt + TW'(1);
      end
    end

    if (perr_n || ferr_n) begin
      brk_pend_n = 1'b0;
      ext_pend_n = 1'b0;
    end

    if (good) begin
      valid_n = 1'b1;
      pay_n   = shreg;
      if (shreg == 8'hF0) begin
        brk_pend_n = 1'b1;
      end else if (shreg == 8'hE0) begin
        ext_pend_n = 1'b1;
      end else begin
        brk_pend_n = 1'b0;
        ext_pend_n = 1'b0;
        if (!ext_pend) begin
          unique case (shreg)
            8'h1D:   keys_n[0] = !brk_pend;
            8'h1B:   keys_n[1] = !brk_pend;
            8'h1C:   keys_n[2] = !brk_pend;
            8'h23:   keys_n[3] = !brk_pend;
            8'h29:   keys_n[4] = !brk_pend;
            8'h5A:   keys_n[5] = !brk_pend;
            default: ;
          endcase
        end
      end
    end
  end

  assign rx.rd_data_valid   = valid_q;
  assign rx.rd_data_payload = pay_q;
  assign rx.keys_valid      = keys_q;
  assign rx.parity_error    = perr_q;
  assign rx.frame_error     = ferr_q;

endmodule
